// File: rtl/hex_loader_pkg.sv
// hex_loader_pkg: shared states, sizes and word padding helper for the hex loader
package hex_loader_pkg;

    localparam int BYTE_SIZE = 8;
    localparam int MAX_BYTES = 8;
    localparam int MAX_W = BYTE_SIZE * MAX_BYTES;

    typedef enum logic [2:0] {IDLE, FETCH, WRITE, FLUSH, DONE, ERR} loader_state_t;

    // Moves the nbytes right-justified low bytes of word to the top of a word_bytes-wide word, zero-filling below
    function automatic logic [MAX_W-1:0] pad_word(input logic [MAX_W-1:0] word, input int nbytes, input int word_bytes);
        return word << (BYTE_SIZE * (word_bytes - nbytes));
    endfunction

endpackage

// File: rtl/hex_loader_ctrl_word_assembler.sv
// word_assembler: big-endian byte shift register with byte index for the hex loader
module word_assembler
    import hex_loader_pkg::*;
#(
    parameter int WORD_BYTES = 4,
    parameter int IDX_W = $clog2(WORD_BYTES) + 1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            clr,
    input  logic                            shift_en,
    input  logic [BYTE_SIZE-1:0]            byte_in,
    output logic [BYTE_SIZE*WORD_BYTES-1:0] word,
    output logic                            last_byte,
    output logic [IDX_W-1:0]                partial_count
);

    localparam int W = BYTE_SIZE * WORD_BYTES;

    logic [IDX_W-1:0] idx;

    assign last_byte = idx == IDX_W'(WORD_BYTES - 1);
    assign partial_count = idx;

    // New bytes enter at the LSB so the first byte ends up in the MSB; index wraps after a full word
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            word <= '0;
            idx <= '0;
        end else if (shift_en) begin
            word <= (word << BYTE_SIZE) | W'(byte_in);
            idx <= last_byte ? '0 : idx + 1'b1;
        end
    end

endmodule

// File: rtl/hex_loader_ctrl.sv
// hex_loader_ctrl: drains the hex lexer FIFO into program memory as packed big-endian words; HEX_LOADER_CHECKSUM_EN adds a byte checksum output
module hex_loader_ctrl
    import hex_loader_pkg::*;
#(
    parameter int WORD_BYTES = 4,
    parameter int ADDR_W = 10,
    parameter int MEM_WORDS = 1024
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start,
    input  logic                            eof,
    input  logic                            lex_empty,
    input  logic [7:0]                      lex_data,
    input  logic                            lex_error,
    output logic                            lex_pop,
    output logic                            mem_we,
    output logic [ADDR_W-1:0]               mem_addr,
    output logic [8*WORD_BYTES-1:0]         mem_wdata,
    output logic                            busy,
    output logic                            done,
    output logic                            error,
`ifdef HEX_LOADER_CHECKSUM_EN
    output logic [7:0]                      checksum,
`endif
    output logic [ADDR_W:0]                 word_count
);

    localparam int W = BYTE_SIZE * WORD_BYTES;
    localparam int IDX_W = $clog2(WORD_BYTES) + 1;
    localparam logic [ADDR_W:0] LIMIT = (ADDR_W + 1)'(MEM_WORDS);

    loader_state_t state, nxt;
    logic [ADDR_W:0] cnt;
    logic [ADDR_W-1:0] addr_q;
    logic [W-1:0] data_q, word, wr_data;
    logic [MAX_W-1:0] padded;
    logic [IDX_W-1:0] partial_count;
    logic eof_seen, last_byte, clr, write;

    assign busy = state inside {FETCH, WRITE, FLUSH};
    assign done = state == DONE;
    assign error = state == ERR;
    assign clr = start && !busy;
    assign word_count = cnt;
    assign mem_we = write;
    assign padded = pad_word(MAX_W'(word), int'(partial_count), WORD_BYTES);
    assign wr_data = state == FLUSH ? padded[W-1:0] : word;
    assign mem_addr = mem_we ? cnt[ADDR_W-1:0] : addr_q;
    assign mem_wdata = mem_we ? wr_data : data_q;

    word_assembler #(.WORD_BYTES(WORD_BYTES), .IDX_W(IDX_W)) u_asm (
        .clk(clk),
        .rst(rst),
        .clr(clr),
        .shift_en(lex_pop),
        .byte_in(lex_data),
        .word(word),
        .last_byte(last_byte),
        .partial_count(partial_count)
    );

    // Next state, pop and write strobe; a lexer error suppresses both pop and write
    always_comb begin
        nxt = state;
        lex_pop = 1'b0;
        write = 1'b0;
        case (state)
            IDLE, DONE, ERR: nxt = start ? FETCH : state;
            FETCH: begin
                if (lex_error) nxt = ERR;
                else if (!lex_empty) begin
                    if (cnt == LIMIT) nxt = ERR;
                    else begin
                        lex_pop = 1'b1;
                        nxt = last_byte ? WRITE : FETCH;
                    end
                end else if (eof_seen || eof) nxt = partial_count != '0 ? FLUSH : DONE;
            end
            WRITE, FLUSH: begin
                write = !lex_error;
                nxt = lex_error ? ERR : (state == WRITE ? FETCH : DONE);
            end
            default: nxt = IDLE;
        endcase
    end

    // State, word counter, end-of-input latch and held memory bus values
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt <= '0;
            addr_q <= '0;
            data_q <= '0;
            eof_seen <= 1'b0;
        end else begin
            state <= nxt;
            if (clr) begin
                cnt <= '0;
                eof_seen <= 1'b0;
            end else begin
                if (busy && eof) eof_seen <= 1'b1;
                if (mem_we) begin
                    cnt <= cnt + 1'b1;
                    addr_q <= mem_addr;
                    data_q <= mem_wdata;
                end
            end
        end
    end

`ifdef HEX_LOADER_CHECKSUM_EN
    // Running modulo-256 sum of every byte popped in this load
    always_ff @(posedge clk) begin
        if (rst || clr) checksum <= '0;
        else if (lex_pop) checksum <= checksum + lex_data;
    end
`endif

endmodule

// File: tb/tb_hex_loader_ctrl.sv
// tb_hex_loader_ctrl: scoreboard bench for hex_loader_ctrl with a small MEM_WORDS to reach overflow
module tb_hex_loader_ctrl;

    localparam int WB = 4;
    localparam int AW = 10;
    localparam int MW = 2;

    typedef struct {
        string name;
        int sel;
        logic [31:0] val;
    } stat_t;

    logic clk = 0, rst = 1, start = 0, eof = 0, lex_error = 0;
    logic lex_empty = 1;
    logic [7:0] lex_data = 0;
    logic lex_pop, mem_we, busy, done, error;
    logic [AW-1:0] mem_addr;
    logic [8*WB-1:0] mem_wdata;
    logic [AW:0] word_count;
`ifdef HEX_LOADER_CHECKSUM_EN
    logic [7:0] checksum;
`endif

    int checks = 0, failures = 0;
    logic [7:0] fmem [0:63];
    int head = 0, tail = 0;
    logic pop_pending = 0, flush_req = 0;
    logic [AW+31:0] exp_q[$];
    logic [AW+31:0] e;
    stat_t stat_q[$];
    stat_t s;
    logic [31:0] act;

    always #5 clk = ~clk;

    hex_loader_ctrl #(.WORD_BYTES(WB), .ADDR_W(AW), .MEM_WORDS(MW)) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .eof(eof),
        .lex_empty(lex_empty),
        .lex_data(lex_data),
        .lex_error(lex_error),
        .lex_pop(lex_pop),
        .mem_we(mem_we),
        .mem_addr(mem_addr),
        .mem_wdata(mem_wdata),
        .busy(busy),
        .done(done),
        .error(error),
`ifdef HEX_LOADER_CHECKSUM_EN
        .checksum(checksum),
`endif
        .word_count(word_count)
    );

    // Lexer FIFO model: pop decided mid-cycle, applied just after the edge
    always @(negedge clk) pop_pending = lex_pop;

    always @(posedge clk) begin
        #1;
        if (pop_pending) head = head + 1;
        if (flush_req) head = tail;
        lex_empty = head == tail;
        lex_data = lex_empty ? 8'h00 : fmem[head % 64];
    end

    function automatic logic [31:0] sample(input int sel);
        case (sel)
            0: return 32'(done);
            1: return 32'(error);
            2: return 32'(busy);
            3: return 32'(word_count);
            4: return 32'(lex_empty);
            5: return 32'(mem_we);
            6: return 32'(mem_addr);
            7: return mem_wdata;
`ifdef HEX_LOADER_CHECKSUM_EN
            8: return 32'(checksum);
`endif
            9: return 32'(exp_q.size());
            10: return 32'd1;
            11: return 32'(lex_pop);
            default: return 32'hdead_beef;
        endcase
    endfunction

    // Monitor: compares every write against the scoreboard and services queued status checks
    always @(negedge clk) begin
        if (mem_we) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_write actual addr=%0h data=%h required no write", mem_addr, mem_wdata);
            end else begin
                e = exp_q.pop_front();
                if ({mem_addr, mem_wdata} !== e) begin
                    failures++;
                    $display("FAIL mem_write actual addr=%0h data=%h required addr=%0h data=%h",
                             mem_addr, mem_wdata, e[AW+31:32], e[31:0]);
                end
            end
        end
        while (stat_q.size() != 0) begin
            s = stat_q.pop_front();
            act = sample(s.sel);
            checks++;
            if (act !== s.val) begin
                failures++;
                $display("FAIL %s actual=%0h required=%0h", s.name, act, s.val);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic st(input string name, input int sel, input logic [31:0] val);
        stat_q.push_back('{name, sel, val});
    endtask

    task automatic expect_wr(input logic [AW-1:0] a, input logic [31:0] d);
        exp_q.push_back({a, d});
    endtask

    task automatic push(input logic [7:0] b);
        fmem[tail % 64] = b;
        tail = tail + 1;
    endtask

    task automatic pulse_start();
        start = 1;
        tick();
        start = 0;
    endtask

    task automatic pulse_eof();
        eof = 1;
        tick();
        eof = 0;
    endtask

    task automatic wait_end(input string name, input int bound);
        int n = 0;
        while (!(done || error) && n < bound) begin
            tick();
            n++;
        end
        if (!(done || error)) st({name, "_timeout"}, 10, 0);
    endtask

    task automatic status(input string name, input logic d, input logic er, input int wc);
        st({name, "_done"}, 0, 32'(d));
        st({name, "_error"}, 1, 32'(er));
        st({name, "_busy"}, 2, 0);
        st({name, "_word_count"}, 3, wc);
    endtask

    initial begin
        repeat (3) tick();
        st("rst_busy", 2, 0);
        st("rst_done", 0, 0);
        st("rst_error", 1, 0);
        st("rst_word_count", 3, 0);
        st("rst_mem_we", 5, 0);
        st("rst_mem_addr", 6, 0);
        st("rst_mem_wdata", 7, 0);
        rst = 0;
        tick();
        st("idle_lex_pop", 11, 0);

        // Two full words
        expect_wr(0, 32'h01020304);
        expect_wr(1, 32'h05060708);
        pulse_start();
        for (int i = 1; i <= 8; i++) push(8'(i));
        tick();
        pulse_eof();
        wait_end("full", 40);
        status("full", 1, 0, 2);

        // Partial final word is flushed left-justified
        expect_wr(0, 32'h11223344);
        expect_wr(1, 32'h55660000);
        pulse_start();
        push(8'h11); push(8'h22); push(8'h33); push(8'h44); push(8'h55); push(8'h66);
        tick();
        pulse_eof();
        wait_end("flush", 40);
        status("flush", 1, 0, 2);

        // Empty load
        pulse_start();
        pulse_eof();
        wait_end("empty", 2);
        status("empty", 1, 0, 0);

        // Overflow: the ninth byte stays in the FIFO
        expect_wr(0, 32'h21222324);
        expect_wr(1, 32'h25262728);
        pulse_start();
        for (int i = 0; i < 9; i++) push(8'(8'h21 + i));
        tick();
        wait_end("ovf", 60);
        status("ovf", 0, 1, 2);
        st("ovf_lex_empty", 4, 0);
        tick();
        flush_req = 1;
        tick();
        flush_req = 0;

        // Lexer error after 3 bytes, then a clean reload
        pulse_start();
        push(8'h31); push(8'h32); push(8'h33);
        repeat (6) tick();
        lex_error = 1;
        tick();
        lex_error = 0;
        status("lexerr", 0, 1, 0);
        tick();
        expect_wr(0, 32'hAABBCCDD);
        pulse_start();
        push(8'hAA); push(8'hBB); push(8'hCC); push(8'hDD);
        tick();
        pulse_eof();
        wait_end("reload", 40);
        status("reload", 1, 0, 1);

        // Checksum load
        expect_wr(0, 32'hFF011020);
        pulse_start();
        push(8'hFF); push(8'h01); push(8'h10); push(8'h20);
        tick();
        pulse_eof();
        wait_end("csum", 40);
        status("csum", 1, 0, 1);
`ifdef HEX_LOADER_CHECKSUM_EN
        st("csum_value", 8, 32'h30);
`endif

        // Reset in the middle of WRITE
        expect_wr(0, 32'hFF011020);
        pulse_start();
        push(8'hFF); push(8'h01); push(8'h10); push(8'h20);
        begin
            int n = 0;
            while (!mem_we && n < 20) begin
                tick();
                n++;
            end
            if (!mem_we) st("rstw_timeout", 10, 0);
        end
        rst = 1;
        tick();
        rst = 0;
        status("rstw", 0, 0, 0);
        st("rstw_mem_we", 5, 0);
        st("rstw_mem_addr", 6, 0);
        st("rstw_mem_wdata", 7, 0);
`ifdef HEX_LOADER_CHECKSUM_EN
        st("rstw_checksum", 8, 0);
`endif
        repeat (2) tick();
        st("pending_writes", 9, 0);
        repeat (2) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hex_loader_ctrl.md
Name: hex_loader_ctrl

Overview:
Sequencer that drains the hex lexer's byte FIFO and loads the bytes into program memory as packed words. It sits between the hex lexer (UART hex-text front end) and the instruction/data RAM of the ULM core. It counts words, flushes a partial word at end-of-input, and reports done/error to the boot logic.

Parameters:
WORD_BYTES, 4, bytes per memory word; first received byte goes to the MSB (big-endian).
ADDR_W, 10, memory word-address width.
MEM_WORDS, 1024, number of loadable words, at most 2**ADDR_W.

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
start  in  1  one-cycle pulse; begins a load at address 0 and clears done/error/count
eof  in  1  one-cycle pulse; no further lexer bytes will arrive for this load
lex_empty  in  1  lexer FIFO empty
lex_data  in  8  lexer FIFO front byte; valid while lex_empty=0
lex_error  in  1  lexer FIFO overflow/underflow flag
lex_pop  out  1  pop lexer FIFO front (combinational)
mem_we  out  1  memory write strobe
mem_addr  out  ADDR_W  memory word address
mem_wdata  out  8*WORD_BYTES  memory write data
busy  out  1  load in progress
done  out  1  load finished without error (sticky)
error  out  1  load aborted (sticky)
word_count  out  ADDR_W+1  words written in the current or last load

Behaviour:
- Reset: state IDLE; lex_pop=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, done=0, error=0, word_count=0; byte index=0; eof_seen=0.
- States: IDLE, FETCH, WRITE, FLUSH, DONE, ERR.
- IDLE/DONE/ERR: start -> FETCH. Clear addr, byte index, word register, word_count, eof_seen, done, error. lex_pop=0 in these states; bytes stay in the FIFO.
- FETCH: lex_pop = !lex_empty (same cycle). On a pop, lex_data shifts into the word register from the LSB side (previous contents shift left 8), and the byte index increments. When the popped byte is byte WORD_BYTES-1, go to WRITE and reset the index to 0.
- WRITE (1 cycle): mem_we=1, mem_addr=addr, mem_wdata=word. Then addr++, word_count++, and go back to FETCH. No pop in this state. Best-case throughput is one word per WORD_BYTES+1 cycles.
- eof: latched into eof_seen in any busy state. If eof and a byte arrive in the same cycle, the byte is consumed first.
- End of input, in FETCH with lex_empty=1 and eof_seen=1:
  - byte index != 0: go to FLUSH. Left-justify the partial word, zero-pad the low bytes, then perform one write as in WRITE and go to DONE.
  - byte index = 0: go directly to DONE.
- DONE: done=1, busy=0.
- Overflow: a byte is available in FETCH while addr == MEM_WORDS -> ERR. That byte is not popped.
- lex_error=1 in any busy state -> ERR on the next cycle, with no memory write in the same cycle as the transition.
- ERR: error=1, busy=0. A partial word is discarded.
- busy=1 in FETCH, WRITE and FLUSH.
- start while busy is ignored.
- rst mid-load returns everything to reset values. Memory contents already written are not rolled back.
- mem_wdata and mem_addr hold their last value when mem_we=0.

Optional Feature:
HEX_LOADER_CHECKSUM_EN
- Defined: adds output checksum[7:0], the modulo-256 sum of all popped bytes in the current load. It is cleared on start and rst and is valid when done=1. Zero pad bytes are not summed.
- Undefined: the port and its logic are absent.

Decomposition:
- Package hex_loader_pkg:
  - loader_state_t enum (IDLE, FETCH, WRITE, FLUSH, DONE, ERR).
  - BYTE_SIZE=8.
  - Function pad_word(word, nbytes), which left-justifies a partial word.
- Sub-module word_assembler:
  - Holds the shift register and byte index.
  - Inputs: clk, rst, clr, shift_en, byte_in.
  - Outputs: word, last_byte, partial_count.

Test Plan:
- start; push 8 bytes 01..08; eof -> writes addr0=0x01020304 and addr1=0x05060708; done=1, word_count=2, error=0.
- start; push 6 bytes 11,22,33,44,55,66; eof -> addr1=0x55660000 (flush); done=1, word_count=2.
- start; eof with FIFO empty -> no mem_we; done=1 within 2 cycles, word_count=0.
- MEM_WORDS=2; push 9 bytes -> 2 writes, then error=1 with one byte left in the FIFO (lex_empty=0), done=0.
- Assert lex_error after 3 bytes -> error=1, no mem_we ever; a subsequent start clears error and a fresh load of 4 bytes succeeds.
- rst asserted during WRITE -> all outputs return to 0; with HEX_LOADER_CHECKSUM_EN, bytes FF,01,10,20 give checksum=0x30.
